load_value_predictor: RTL and testbench

// - Last-value predictor for loads that miss the D-cache. Sits beside the hazard controller, downstream of it.
// - Hazard controller raises vp_en with the load PC. This block supplies a speculative value to MEM while the miss is outstanding.
// - On cache fill it checks the prediction and trains its table.
// - It then signals done (correct) or recover (mispredict); the hazard controller uses recover to restore the register snapshot.

---
 rtl/vp_pkg.sv | 33 +++
 rtl/load_value_predictor_if.sv | 29 ++
 rtl/lvp_table.sv | 39 +++
 rtl/load_value_predictor.sv | 144 ++++++++++++++
 tb/tb_load_value_predictor.sv | 197 +++++++++++++++++++
 5 files changed

// File: rtl/vp_pkg.sv
// Shared types and geometry for the load value predictor: table entry layout,
// FSM states and the PC-to-index/tag split.
package vp_pkg;

  localparam int DATA_WIDTH = 32;
  localparam int INDEX_BITS = 6;
  localparam int CONF_BITS  = 2;
  localparam int TAG_BITS   = DATA_WIDTH - INDEX_BITS - 2;
  localparam int ENTRIES    = 1 << INDEX_BITS;

  typedef enum logic [1:0] {
    VP_IDLE,
    VP_WAIT_MEM,
    VP_RECOVER
  } vp_state_t;

  typedef struct packed {
    logic                  valid;
    logic [TAG_BITS-1:0]   tag;
    logic [DATA_WIDTH-1:0] value;
    logic [CONF_BITS-1:0]  conf;
  } vp_entry_t;

  // Word-aligned loads: bits [1:0] never take part in indexing or tagging.
  function automatic logic [INDEX_BITS-1:0] pc_index(input logic [DATA_WIDTH-1:0] pc);
    return pc[INDEX_BITS+1:2];
  endfunction

  function automatic logic [TAG_BITS-1:0] pc_tag(input logic [DATA_WIDTH-1:0] pc);
    return pc[DATA_WIDTH-1:INDEX_BITS+2];
  endfunction

endpackage

// File: rtl/load_value_predictor_if.sv
// Handshake between the hazard controller (master) and the load value
// predictor (slave), including the predictor's statistics outputs.
interface load_value_predictor_if;

  logic                          vp_en;
  logic [vp_pkg::DATA_WIDTH-1:0] pc;
  logic                          dc_valid;
  logic [vp_pkg::DATA_WIDTH-1:0] dc_data;
  logic                          recovery_done;
  logic                          pred_valid;
  logic [vp_pkg::DATA_WIDTH-1:0] pred_data;
  logic                          vp_lock;
  logic                          done;
  logic                          recover;
  logic [vp_pkg::DATA_WIDTH-1:0] last_pc;
  logic [31:0]                   hit_cnt;
  logic [31:0]                   miss_cnt;

  modport master (
    output vp_en, pc, dc_valid, dc_data, recovery_done,
    input  pred_valid, pred_data, vp_lock, done, recover, last_pc, hit_cnt, miss_cnt
  );

  modport slave (
    input  vp_en, pc, dc_valid, dc_data, recovery_done,
    output pred_valid, pred_data, vp_lock, done, recover, last_pc, hit_cnt, miss_cnt
  );

endinterface

// File: rtl/lvp_table.sv
// Direct-mapped last-value table: combinational read, one registered write,
// valid bits cleared asynchronously on reset.
module lvp_table
  import vp_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic [INDEX_BITS-1:0] rd_idx,
  output vp_entry_t             rd_entry,
  input  logic                  wr_en,
  input  logic [INDEX_BITS-1:0] wr_idx,
  input  vp_entry_t             wr_entry
);

  logic [ENTRIES-1:0] valid_q;
  vp_entry_t          mem [ENTRIES];

  always_comb begin
    rd_entry       = mem[rd_idx];
    rd_entry.valid = valid_q[rd_idx];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
    end else if (wr_en) begin
      valid_q[wr_idx] <= wr_entry.valid;
    end
  end

  // NOTE: only the valid bits need a reset; the payload array is left
  // unreset so it maps onto plain RAM and is never trusted while invalid.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_idx] <= wr_entry;
    end
  end

endmodule

// File: rtl/load_value_predictor.sv
// Last-value predictor for D-cache load misses: issues a speculative value while
// the fill is outstanding, verifies and trains on the fill, and signals done/recover.
module load_value_predictor
  import vp_pkg::*;
#(
  parameter int MAX_WAIT    = 255,
  parameter int CONF_THRESH = 2
) (
  input logic                   clk,
  input logic                   rst,
  load_value_predictor_if.slave bus
);

  localparam int                   WAIT_W    = $clog2(MAX_WAIT + 1);
  localparam logic [WAIT_W-1:0]    LAST_WAIT = WAIT_W'(MAX_WAIT - 1);
  localparam logic [CONF_BITS-1:0] THRESH    = CONF_BITS'(CONF_THRESH);
  localparam logic [CONF_BITS-1:0] CONF_MAX  = '1;

  vp_state_t             state;
  logic [WAIT_W-1:0]     wait_cnt;
  logic [DATA_WIDTH-1:0] last_pc_q;
  logic [DATA_WIDTH-1:0] pred_data_q;
  logic                  pred_valid_q;
  logic                  predicted_q;
  logic                  vp_lock_q;
  logic                  done_q;
  logic                  recover_q;
  logic [31:0]           hit_cnt_q;
  logic [31:0]           miss_cnt_q;

  logic [DATA_WIDTH-1:0] rd_pc;
  vp_entry_t             rd_entry;
  vp_entry_t             wr_entry;
  logic                  tag_hit;
  logic                  predict_now;
  logic                  value_match;
  logic                  fill;
  logic                  timeout;

  // In IDLE the table is probed with the incoming PC; afterwards with the
  // latched one, so the fill trains the same entry that made the prediction.
  assign rd_pc       = (state == VP_IDLE) ? bus.pc : last_pc_q;
  assign tag_hit     = rd_entry.valid && (rd_entry.tag == pc_tag(rd_pc));
  assign predict_now = tag_hit && (rd_entry.conf >= THRESH);
  assign value_match = tag_hit && (rd_entry.value == bus.dc_data);
  assign fill        = (state == VP_WAIT_MEM) && bus.dc_valid;
  assign timeout     = (state == VP_WAIT_MEM) && !bus.dc_valid && (wait_cnt == LAST_WAIT);

  lvp_table u_table (
    .clk      (clk),
    .rst      (rst),
    .rd_idx   (pc_index(rd_pc)),
    .rd_entry (rd_entry),
    .wr_en    (fill),
    .wr_idx   (pc_index(last_pc_q)),
    .wr_entry (wr_entry)
  );

  // NOTE: wr_entry gets a full default before any branch, so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    wr_entry = rd_entry;
    if (value_match) begin
      if (rd_entry.conf != CONF_MAX) begin
        wr_entry.conf = rd_entry.conf + 1'b1;
      end
    end else begin
      wr_entry = '{valid: 1'b1, tag: pc_tag(last_pc_q), value: bus.dc_data, conf: '0};
    end
  end

  // NOTE: every register here uses non-blocking assignment so all decisions
  // in a cycle are made from pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= VP_IDLE;
      wait_cnt     <= '0;
      last_pc_q    <= '0;
      pred_data_q  <= '0;
      pred_valid_q <= 1'b0;
      predicted_q  <= 1'b0;
      vp_lock_q    <= 1'b0;
      done_q       <= 1'b0;
      recover_q    <= 1'b0;
      hit_cnt_q    <= '0;
      miss_cnt_q   <= '0;
    end else begin
      done_q    <= 1'b0;
      recover_q <= 1'b0;
      case (state)
        VP_IDLE: begin
          if (bus.vp_en) begin
            last_pc_q    <= bus.pc;
            predicted_q  <= predict_now;
            pred_valid_q <= predict_now;
            pred_data_q  <= predict_now ? rd_entry.value : '0;
            vp_lock_q    <= 1'b1;
            wait_cnt     <= '0;
            state        <= VP_WAIT_MEM;
          end
        end
        VP_WAIT_MEM: begin
          wait_cnt <= wait_cnt + 1'b1;
          if (fill || timeout) begin
            pred_valid_q <= 1'b0;
            if (predicted_q && fill && value_match) begin
              done_q    <= 1'b1;
              hit_cnt_q <= hit_cnt_q + 32'd1;
              vp_lock_q <= 1'b0;
              state     <= VP_IDLE;
            end else if (predicted_q) begin
              recover_q  <= 1'b1;
              miss_cnt_q <= miss_cnt_q + 32'd1;
              state      <= VP_RECOVER;
            end else begin
              vp_lock_q <= 1'b0;
              state     <= VP_IDLE;
            end
          end
        end
        VP_RECOVER: begin
          if (bus.recovery_done) begin
            vp_lock_q <= 1'b0;
            state     <= VP_IDLE;
          end
        end
        default: begin
          vp_lock_q <= 1'b0;
          state     <= VP_IDLE;
        end
      endcase
    end
  end

  assign bus.pred_valid = pred_valid_q;
  assign bus.pred_data  = pred_data_q;
  assign bus.vp_lock    = vp_lock_q;
  assign bus.done       = done_q;
  assign bus.recover    = recover_q;
  assign bus.last_pc    = last_pc_q;
  assign bus.hit_cnt    = hit_cnt_q;
  assign bus.miss_cnt   = miss_cnt_q;

endmodule

// File: tb/tb_load_value_predictor.sv
// Directed bench for load_value_predictor: a transaction-level table model sets
// expected outputs, a negedge process compares them every cycle.
module tb_load_value_predictor;

  localparam int TB_MAX_WAIT = 8;
  localparam int TB_THRESH   = 2;
  localparam int TB_CONF_MAX = 3;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  load_value_predictor_if bus ();

  load_value_predictor #(
    .MAX_WAIT    (TB_MAX_WAIT),
    .CONF_THRESH (TB_THRESH)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;

  // Table model: one slot per index, holding the full PC that trained it.
  bit          m_valid [64];
  logic [31:0] m_pc    [64];
  logic [31:0] m_value [64];
  int          m_conf  [64];

  bit          chk_en;
  bit          exp_lock, exp_pv, exp_done, exp_rec;
  logic [31:0] exp_pd, exp_last, exp_hit, exp_miss;
  logic        obs_pv;
  logic [31:0] obs_pd;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("vp_lock",    32'(bus.vp_lock),    32'(exp_lock));
      check("pred_valid", 32'(bus.pred_valid), 32'(exp_pv));
      check("done",       32'(bus.done),       32'(exp_done));
      check("recover",    32'(bus.recover),    32'(exp_rec));
      check("hit_cnt",    bus.hit_cnt,         exp_hit);
      check("miss_cnt",   bus.miss_cnt,        exp_miss);
      check("last_pc",    bus.last_pc,         exp_last);
      if (exp_pv) check("pred_data", bus.pred_data, exp_pd);
    end
  end

  task automatic clear_expect();
    exp_lock = 0; exp_pv = 0; exp_done = 0; exp_rec = 0;
    exp_pd = 0; exp_last = 0; exp_hit = 0; exp_miss = 0;
    for (int i = 0; i < 64; i++) m_valid[i] = 0;
  endtask

  // One missed load: dly = wait cycle (1-based) carrying the fill, 0 = no fill.
  task automatic run_load(input logic [31:0] a, input logic [31:0] d, input int dly,
                          input int rec_dly, input bit noise);
    int idx;
    bit hit, pred, fill, ok;
    int end_k;
    idx   = int'((a >> 2) % 64);
    hit   = m_valid[idx] && ((m_pc[idx] >> 8) == (a >> 8));
    pred  = hit && (m_conf[idx] >= TB_THRESH);
    fill  = (dly >= 1) && (dly <= TB_MAX_WAIT);
    end_k = fill ? dly : TB_MAX_WAIT;

    bus.pc = a; bus.vp_en = 1;
    @(posedge clk); #1;
    bus.vp_en = 0;
    exp_lock = 1; exp_pv = pred; exp_pd = pred ? m_value[idx] : 32'd0; exp_last = a;
    obs_pv = bus.pred_valid; obs_pd = bus.pred_data;

    for (int k = 1; k <= end_k; k++) begin
      if (noise) begin bus.vp_en = 1; bus.pc = a ^ 32'h0000_1000; end
      if (fill && k == dly) begin bus.dc_valid = 1; bus.dc_data = d; end
      @(posedge clk); #1;
      bus.dc_valid = 0; bus.vp_en = 0;
    end

    ok       = fill && pred && (m_value[idx] == d);
    exp_pv   = 0;
    exp_done = ok;
    exp_rec  = pred && !ok;
    if (exp_done) exp_hit++;
    if (exp_rec)  exp_miss++;
    exp_lock = exp_rec;
    if (fill) begin
      if (hit && m_value[idx] == d) begin
        if (m_conf[idx] < TB_CONF_MAX) m_conf[idx]++;
      end else begin
        m_valid[idx] = 1; m_pc[idx] = a; m_value[idx] = d; m_conf[idx] = 0;
      end
    end

    if (exp_rec) begin
      for (int k = 0; k < rec_dly; k++) begin
        @(posedge clk); #1;
        exp_rec = 0;
      end
      bus.recovery_done = 1;
      @(posedge clk); #1;
      bus.recovery_done = 0; exp_rec = 0; exp_lock = 0;
    end
    @(posedge clk); #1;
    exp_done = 0; exp_rec = 0;
  endtask

  initial begin
    rst = 1;
    bus.vp_en = 0; bus.pc = 0; bus.dc_valid = 0; bus.dc_data = 0; bus.recovery_done = 0;
    chk_en = 0;
    obs_pv = 0; obs_pd = 0;
    clear_expect();
    repeat (2) @(posedge clk);
    #1;
    chk_en = 1;
    check("rst_pred_valid", 32'(bus.pred_valid), 32'd0);
    check("rst_vp_lock",    32'(bus.vp_lock),    32'd0);
    check("rst_hit_cnt",    bus.hit_cnt,         32'd0);
    @(posedge clk); #1;
    rst = 0;

    // Cold table, then warm-up to confidence 2 and a verified hit.
    run_load(32'h0000_0400, 32'h0000_DEAD, 3, 0, 0);
    check("cold_no_pred", 32'(obs_pv), 32'd0);
    run_load(32'h0000_0400, 32'h0000_DEAD, 1, 0, 0);
    run_load(32'h0000_0400, 32'h0000_DEAD, 2, 0, 0);
    run_load(32'h0000_0400, 32'h0000_DEAD, 4, 0, 0);
    check("warm_pred_valid", 32'(obs_pv), 32'd1);
    check("warm_pred_data",  obs_pd,      32'h0000_DEAD);
    check("warm_hit_cnt",    bus.hit_cnt, 32'd1);

    // Mispredict with a slow snapshot restore.
    run_load(32'h0000_0400, 32'h0000_BEEF, 2, 3, 0);
    check("mis_pred_valid", 32'(obs_pv),  32'd1);
    check("mis_miss_cnt",   bus.miss_cnt, 32'd1);
    run_load(32'h0000_0400, 32'h0000_BEEF, 1, 0, 0);
    check("retrain_no_pred", 32'(obs_pv), 32'd0);
    run_load(32'h0000_0400, 32'h0000_BEEF, 1, 0, 0);

    // Alias: same index, different tag replaces the entry.
    run_load(32'h0001_0400, 32'h0000_1234, 4, 0, 0);
    check("alias_no_pred", 32'(obs_pv), 32'd0);
    run_load(32'h0000_0400, 32'h0000_BEEF, 2, 0, 0);
    check("alias_evicted", 32'(obs_pv), 32'd0);

    // Timeout boundary, with ignored vp_en noise while busy.
    run_load(32'h0000_0404, 32'h0000_5555, 1, 0, 0);
    run_load(32'h0000_0404, 32'h0000_5555, 5, 0, 0);
    run_load(32'h0000_0404, 32'h0000_5555, 8, 0, 0);
    run_load(32'h0000_0404, 32'h0000_0000, 0, 0, 1);
    check("timeout_pred",     32'(obs_pv),  32'd1);
    check("timeout_miss_cnt", bus.miss_cnt, 32'd2);
    run_load(32'h0000_0404, 32'h0000_5555, 8, 0, 1);
    check("last_cycle_hit_cnt", bus.hit_cnt, 32'd2);
    run_load(32'h0000_0404, 32'h0000_5555, 2, 0, 0);
    run_load(32'h0000_0404, 32'h0000_5555, 3, 0, 0);
    check("saturated_hit_cnt", bus.hit_cnt, 32'd4);
    run_load(32'h0000_0808, 32'h0000_0000, 0, 0, 0);

    // Asynchronous reset in the middle of WAIT_MEM.
    bus.pc = 32'h0000_0404; bus.vp_en = 1;
    @(posedge clk); #1;
    bus.vp_en = 0;
    exp_lock = 1; exp_pv = 1; exp_pd = 32'h0000_5555; exp_last = 32'h0000_0404;
    @(posedge clk); #1;
    check("pre_rst_pred_valid", 32'(bus.pred_valid), 32'd1);
    rst = 1;
    clear_expect();
    #1;
    check("async_rst_pred_valid", 32'(bus.pred_valid), 32'd0);
    check("async_rst_vp_lock",    32'(bus.vp_lock),    32'd0);
    check("async_rst_recover",    32'(bus.recover),    32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 0;
    run_load(32'h0000_0404, 32'h0000_5555, 3, 0, 0);
    check("post_rst_no_pred", 32'(obs_pv), 32'd0);

    @(posedge clk); #1;
    chk_en = 0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
